// File: rtl/sprite_plotter.sv
// sprite_plotter: raster-scans one SPRITE_W x SPRITE_H sprite out of a
// synchronous sprite RAM, offsets it by a latched screen origin, clips
// off-screen pixels and emits registered per-pixel VGA writes.
// A coordinate/valid shift register of depth RAM_LATENCY lines pixel
// coordinates up with the RAM read data.
// Optional feature macro: SPRITE_PLOTTER_TRANSPARENCY_EN
//   defined   -> pixels whose color equals TRANSPARENT_COLOR are not plotted
//   undefined -> every in-bounds pixel is plotted
//
// state | meaning
// IDLE  | waiting for start; origin latched on accepted start
// SCAN  | issuing one sprite RAM address per cycle, row-major
// DRAIN | flushing RAM_LATENCY+1 cycles of pipeline after last address
// DONE  | one-cycle done pulse, busy low, start ignored
module sprite_plotter #(
  parameter int WIDTH_X           = 8,
  parameter int WIDTH_Y           = 7,
  parameter int SCREEN_W          = 160,
  parameter int SCREEN_H          = 120,
  parameter int SPR_WIDTH_X       = 4,
  parameter int SPR_WIDTH_Y       = 4,
  parameter int SPRITE_W          = 10,
  parameter int SPRITE_H          = 6,
  parameter int COLOR_WIDTH       = 3,
  parameter int RAM_LATENCY       = 1,
  parameter int TRANSPARENT_COLOR = 0
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [WIDTH_X-1:0]     origin_x,
  input  logic [WIDTH_Y-1:0]     origin_y,
  output logic                   busy,
  output logic                   done,
  output logic [SPR_WIDTH_X-1:0] spr_x,
  output logic [SPR_WIDTH_Y-1:0] spr_y,
  input  logic [COLOR_WIDTH-1:0] color_in,
  output logic [WIDTH_X-1:0]     vga_x,
  output logic [WIDTH_Y-1:0]     vga_y,
  output logic [COLOR_WIDTH-1:0] vga_color,
  output logic                   vga_plot
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SCAN  = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam int CNT_W = $clog2(RAM_LATENCY + 2);

`ifdef SPRITE_PLOTTER_TRANSPARENCY_EN
  localparam bit TRANSP_EN = 1'b1;
`else
  localparam bit TRANSP_EN = 1'b0;
`endif

  logic [1:0]             state;
  logic [WIDTH_X-1:0]     org_x;
  logic [WIDTH_Y-1:0]     org_y;
  logic [CNT_W-1:0]       drain_cnt;
  logic                   x_last;
  logic                   addr_last;

  // screen coordinates carry one extra bit so overflow past the right or
  // bottom edge clips instead of wrapping to the opposite edge
  logic [WIDTH_X:0]       sx;
  logic [WIDTH_Y:0]       sy;
  logic                   in_bounds;

  logic                   pipe_v [RAM_LATENCY];
  logic [WIDTH_X-1:0]     pipe_x [RAM_LATENCY];
  logic [WIDTH_Y-1:0]     pipe_y [RAM_LATENCY];

  logic                   is_key;
  logic                   pix_plot;

  assign x_last    = (spr_x == SPR_WIDTH_X'(SPRITE_W - 1));
  assign addr_last = x_last && (spr_y == SPR_WIDTH_Y'(SPRITE_H - 1));

  assign sx = {1'b0, org_x} + {{(WIDTH_X + 1 - SPR_WIDTH_X){1'b0}}, spr_x};
  assign sy = {1'b0, org_y} + {{(WIDTH_Y + 1 - SPR_WIDTH_Y){1'b0}}, spr_y};
  assign in_bounds = (sx < (WIDTH_X + 1)'(SCREEN_W)) && (sy < (WIDTH_Y + 1)'(SCREEN_H));

  assign busy = (state == S_SCAN) || (state == S_DRAIN);
  assign done = (state == S_DONE);

  assign is_key   = (color_in == COLOR_WIDTH'(TRANSPARENT_COLOR));
  assign pix_plot = pipe_v[RAM_LATENCY-1] && !(TRANSP_EN && is_key);

  // sequencing FSM with scan address counters and drain down-counter
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      org_x     <= '0;
      org_y     <= '0;
      spr_x     <= '0;
      spr_y     <= '0;
      drain_cnt <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            org_x <= origin_x;
            org_y <= origin_y;
            spr_x <= '0;
            spr_y <= '0;
            state <= S_SCAN;
          end
        end
        S_SCAN: begin
          if (addr_last) begin
            drain_cnt <= CNT_W'(RAM_LATENCY);
            state     <= S_DRAIN;
          end else if (x_last) begin
            spr_x <= '0;
            spr_y <= spr_y + SPR_WIDTH_Y'(1);
          end else begin
            spr_x <= spr_x + SPR_WIDTH_X'(1);
          end
        end
        S_DRAIN: begin
          if (drain_cnt == '0) begin
            state <= S_DONE;
          end else begin
            drain_cnt <= drain_cnt - CNT_W'(1);
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // delay valid and clipped coordinates to meet the RAM read data
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < RAM_LATENCY; i++) begin
        pipe_v[i] <= 1'b0;
        pipe_x[i] <= '0;
        pipe_y[i] <= '0;
      end
    end else begin
      pipe_v[0] <= (state == S_SCAN) && in_bounds;
      pipe_x[0] <= sx[WIDTH_X-1:0];
      pipe_y[0] <= sy[WIDTH_Y-1:0];
      for (int i = 1; i < RAM_LATENCY; i++) begin
        pipe_v[i] <= pipe_v[i-1];
        pipe_x[i] <= pipe_x[i-1];
        pipe_y[i] <= pipe_y[i-1];
      end
    end
  end

  // registered VGA write; coordinates and color hold between plots
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vga_plot  <= 1'b0;
      vga_x     <= '0;
      vga_y     <= '0;
      vga_color <= '0;
    end else begin
      vga_plot <= pix_plot;
      if (pix_plot) begin
        vga_x     <= pipe_x[RAM_LATENCY-1];
        vga_y     <= pipe_y[RAM_LATENCY-1];
        vga_color <= color_in;
      end
    end
  end

endmodule

// File: tb/tb_sprite_plotter.sv
// Bench for sprite_plotter with a 4x3 sprite, RAM latency 1, 160x120 screen.
module tb_sprite_plotter;

  localparam int SW = 4;
  localparam int SH = 3;
  localparam int NPIX = SW * SH;

`ifdef SPRITE_PLOTTER_TRANSPARENCY_EN
  localparam bit TRANSP = 1'b1;
`else
  localparam bit TRANSP = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [7:0] origin_x;
  logic [6:0] origin_y;
  logic       busy;
  logic       done;
  logic [3:0] spr_x;
  logic [3:0] spr_y;
  logic [2:0] color_in = 3'd0;
  logic [7:0] vga_x;
  logic [6:0] vga_y;
  logic [2:0] vga_color;
  logic       vga_plot;

  int checks   = 0;
  int failures = 0;
  bit tmode    = 1'b0;

  logic [7:0] last_x;
  logic [6:0] last_y;
  logic [2:0] last_c;

  sprite_plotter #(
    .WIDTH_X(8), .WIDTH_Y(7), .SCREEN_W(160), .SCREEN_H(120),
    .SPR_WIDTH_X(4), .SPR_WIDTH_Y(4), .SPRITE_W(SW), .SPRITE_H(SH),
    .COLOR_WIDTH(3), .RAM_LATENCY(1), .TRANSPARENT_COLOR(0)
  ) dut (
    .clk(clk), .reset(reset), .start(start),
    .origin_x(origin_x), .origin_y(origin_y),
    .busy(busy), .done(done),
    .spr_x(spr_x), .spr_y(spr_y), .color_in(color_in),
    .vga_x(vga_x), .vga_y(vga_y), .vga_color(vga_color), .vga_plot(vga_plot)
  );

  always #5 clk = ~clk;

  function automatic logic [2:0] ram_px(input int x, input int y);
    if (tmode) return (x == 1 && y == 1) ? 3'd5 : 3'd0;
    return 3'((y * SW + x) % 8);
  endfunction

  // sprite RAM with one cycle read latency
  always @(posedge clk) color_in <= ram_px(int'(spr_x), int'(spr_y));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_held(input string tag);
    chk({tag, ".vga_x"}, 32'(vga_x), 32'(last_x));
    chk({tag, ".vga_y"}, 32'(vga_y), 32'(last_y));
    chk({tag, ".vga_color"}, 32'(vga_color), 32'(last_c));
  endtask

  // one complete draw; start edge is edge 0, every cycle checked through edge 17
  task automatic draw(input logic [7:0] ox, input logic [6:0] oy, input bit spur);
    bit         ep [NPIX];
    logic [7:0] ex [NPIX];
    logic [6:0] ey [NPIX];
    logic [2:0] ec [NPIX];
    int k;
    bit p;
    for (int y = 0; y < SH; y++) begin
      for (int x = 0; x < SW; x++) begin
        k = y * SW + x;
        ex[k] = 8'(int'(ox) + x);
        ey[k] = 7'(int'(oy) + y);
        ec[k] = ram_px(x, y);
        ep[k] = (int'(ox) + x < 160) && (int'(oy) + y < 120) && !(TRANSP && ec[k] == 3'd0);
      end
    end
    @(negedge clk);
    origin_x = ox;
    origin_y = oy;
    start    = 1'b1;
    @(negedge clk);
    start    = 1'b0;
    origin_x = 8'($urandom);
    origin_y = 7'($urandom);
    chk("e0.busy", 32'(busy), 32'd1);
    chk("e0.spr_x", 32'(spr_x), 32'd0);
    chk("e0.spr_y", 32'(spr_y), 32'd0);
    chk("e0.plot", 32'(vga_plot), 32'd0);
    for (int e = 1; e <= 17; e++) begin
      start = spur && (e == 3 || e == 14 || e == 15);
      @(negedge clk);
      start = 1'b0;
      k = e - 2;
      p = (k >= 0 && k < NPIX) ? ep[k] : 1'b0;
      if (p) begin
        last_x = ex[k];
        last_y = ey[k];
        last_c = ec[k];
      end
      chk($sformatf("e%0d.plot", e), 32'(vga_plot), 32'(p));
      chk_held($sformatf("e%0d", e));
      chk($sformatf("e%0d.done", e), 32'(done), 32'(e == 14));
      chk($sformatf("e%0d.busy", e), 32'(busy), 32'(e <= 13));
      if (e < NPIX) begin
        chk($sformatf("e%0d.spr_x", e), 32'(spr_x), 32'(e % SW));
        chk($sformatf("e%0d.spr_y", e), 32'(spr_y), 32'(e / SW));
      end
    end
  endtask

  initial begin
    reset    = 1'b1;
    start    = 1'b0;
    origin_x = '0;
    origin_y = '0;
    last_x   = '0;
    last_y   = '0;
    last_c   = '0;
    @(negedge clk);
    @(negedge clk);
    chk("rst.busy", 32'(busy), 32'd0);
    chk("rst.done", 32'(done), 32'd0);
    chk("rst.plot", 32'(vga_plot), 32'd0);
    chk("rst.spr_x", 32'(spr_x), 32'd0);
    chk("rst.spr_y", 32'(spr_y), 32'd0);
    chk_held("rst");
    reset = 1'b0;
    @(negedge clk);

    draw(8'd10, 7'd20, 1'b0);
    draw(8'd10, 7'd20, 1'b1);
    draw(8'd158, 7'd118, 1'b1);
    draw(8'd255, 7'd127, 1'b0);
    draw(8'd0, 7'd0, 1'b1);

    // reset in the middle of a scan aborts the draw
    origin_x = 8'd10;
    origin_y = 7'd20;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int e = 1; e <= 5; e++) @(negedge clk);
    reset = 1'b1;
    #1;
    chk("abort.busy", 32'(busy), 32'd0);
    chk("abort.done", 32'(done), 32'd0);
    chk("abort.plot", 32'(vga_plot), 32'd0);
    chk("abort.spr_x", 32'(spr_x), 32'd0);
    chk("abort.spr_y", 32'(spr_y), 32'd0);
    last_x = '0;
    last_y = '0;
    last_c = '0;
    chk_held("abort");
    @(negedge clk);
    reset = 1'b0;
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      chk($sformatf("post_abort%0d.done", c), 32'(done), 32'd0);
      chk($sformatf("post_abort%0d.plot", c), 32'(vga_plot), 32'd0);
      chk($sformatf("post_abort%0d.busy", c), 32'(busy), 32'd0);
    end
    draw(8'd10, 7'd20, 1'b0);

    for (int r = 0; r < 10; r++) begin
      draw(8'($urandom_range(255, 0)), 7'($urandom_range(127, 0)), 1'($urandom));
    end
    draw(8'($urandom_range(159, 150)), 7'($urandom_range(119, 112)), 1'b1);

`ifdef SPRITE_PLOTTER_TRANSPARENCY_EN
    tmode = 1'b1;
    draw(8'd30, 7'd40, 1'b0);
    chk("transp.last_x", 32'(vga_x), 32'd31);
    chk("transp.last_c", 32'(vga_color), 32'd5);
    tmode = 1'b0;
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
